// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide sequencer that owns the architectural HI/LO registers.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DW-1:0]    pend_hi, pend_hi_d, pend_lo, pend_lo_d;
  logic             pend_dz, pend_dz_d;
  logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic [2*DW-1:0]  prod_s, prod_u;
  logic [DW-1:0]    abs_a, abs_b, div_b, q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic             b_zero, md_long_op;

  // Products, and quotient/remainder via magnitudes so the INT_MIN / -1 case wraps cleanly.
  always_comb begin
    prod_s = {{DW{in_a[DW-1]}}, in_a} * {{DW{in_b[DW-1]}}, in_b};
    prod_u = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};
    b_zero = (in_b == '0);
    abs_a  = in_a[DW-1] ? (~in_a + DW'(1)) : in_a;
    abs_b  = in_b[DW-1] ? (~in_b + DW'(1)) : in_b;
    div_b  = b_zero ? DW'(1) : abs_b;
    q_mag  = abs_a / div_b;
    r_mag  = abs_a % div_b;
    quot_s = (in_a[DW-1] ^ in_b[DW-1]) ? (~q_mag + DW'(1)) : q_mag;
    rem_s  = in_a[DW-1] ? (~r_mag + DW'(1)) : r_mag;
    quot_u = in_a / (b_zero ? DW'(1) : in_b);
    rem_u  = in_a % (b_zero ? DW'(1) : in_b);
  end

  // Next-state: accept in idle, count down while busy, commit pending results on the last cycle.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    pend_dz_d = pend_dz;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = (md_op == OP_MULT) ? prod_s[2*DW-1:DW] : prod_u[2*DW-1:DW];
              pend_lo_d = (md_op == OP_MULT) ? prod_s[DW-1:0]    : prod_u[DW-1:0];
              pend_dz_d = 1'b0;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = (md_op == OP_DIV) ? rem_s  : rem_u;
              pend_lo_d = (md_op == OP_DIV) ? quot_s : quot_u;
              pend_dz_d = b_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = in_a;
            OP_MTLO: lo_d = in_a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          if (!pend_dz) begin
            hi_d = pend_hi;
            lo_d = pend_lo;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
      pend_dz <= pend_dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall the D-stage HI/LO user while a long op is in flight or being launched this cycle.
  always_comb begin
    md_long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                 (md_op == OP_DIV)  || (md_op == OP_DIVU);
    stall_md   = md_use_d & ((state == S_BUSY) | (start & md_long_op));
  end

  assign busy = (state == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed vectors for the multiply/divide controller.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] in_a, in_b;
  logic        md_use_d;
  logic        busy, stall_md;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .md_op    (md_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a long op in the current cycle and check busy over cycles 1..n and idle in n+1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n);
    start = 1'b1; md_op = op; in_a = a; in_b = b;
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("busy_op%0d_c%0d", op, c), 32'(busy), 32'd1);
      tick();
    end
    chk($sformatf("idle_op%0d", op), 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; md_op = 3'd0; in_a = '0; in_b = '0; md_use_d = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_stall", 32'(stall_md), 32'd0);

    // MULT -3 * 5, HI must hold until commit
    start = 1'b1; md_op = 3'd1; in_a = 32'hFFFF_FFFD; in_b = 32'd5;
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("mult_busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("mult_hold_c%0d", c), HI, 32'h0);
      tick();
    end
    chk("mult_idle", 32'(busy), 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);

    run_op(3'd2, 32'hFFFF_FFFD, 32'd5, 5);
    chk("multu_hi", HI, 32'h0000_0004);
    chk("multu_lo", LO, 32'hFFFF_FFF1);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    run_op(3'd4, 32'd7, 32'd2, 10);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_hi", HI, 32'h0);
    chk("divovf_lo", LO, 32'h8000_0000);

    // MTHI / MTLO preload, no latency
    start = 1'b1; md_op = 3'd5; in_a = 32'h11;
    tick();
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", HI, 32'h11);
    md_op = 3'd6; in_a = 32'h22;
    tick();
    start = 1'b0; md_op = 3'd0;
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi_keep", HI, 32'h11);

    // divide by zero leaves HI/LO untouched
    run_op(3'd3, 32'd5, 32'd0, 10);
    chk("dz_hi", HI, 32'h11);
    chk("dz_lo", LO, 32'h22);

    // reserved op 7 and NONE: no state change
    start = 1'b1; md_op = 3'd7; in_a = 32'hDEAD_BEEF; in_b = 32'd3;
    tick();
    md_op = 3'd0;
    tick();
    start = 1'b0;
    chk("op7_busy", 32'(busy), 32'd0);
    chk("op7_hi", HI, 32'h11);
    chk("op7_lo", LO, 32'h22);

    // MTHI launch does not stall a D-stage user
    md_use_d = 1'b1; start = 1'b1; md_op = 3'd5;
    #1;
    chk("stall_mthi", 32'(stall_md), 32'd0);
    start = 1'b0; md_op = 3'd0;
    #1;
    chk("stall_idle", 32'(stall_md), 32'd0);

    // MULT with D-stage user: stall cycles 0..5; MTHI in cycle 3 ignored
    start = 1'b1; md_op = 3'd1; in_a = 32'hFFFF_FFFD; in_b = 32'd5;
    #1;
    chk("stall_c0", 32'(stall_md), 32'd1);
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin
        start = 1'b1; md_op = 3'd5; in_a = 32'hDEAD_0000;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      #1;
      chk($sformatf("stall_c%0d", c), 32'(stall_md), 32'd1);
      tick();
    end
    start = 1'b0; md_op = 3'd0;
    chk("stall_c6", 32'(stall_md), 32'd0);
    chk("stallmult_hi", HI, 32'hFFFF_FFFF);
    chk("stallmult_lo", LO, 32'hFFFF_FFF1);
    md_use_d = 1'b0;

    // back-to-back: accept in the first idle cycle
    run_op(3'd2, 32'hFFFF_FFFD, 32'd5, 5);
    chk("b2b_hi", HI, 32'h0000_0004);

    // reset mid-DIVU aborts without late commit
    start = 1'b1; md_op = 3'd4; in_a = 32'd100; in_b = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    for (int c = 0; c < 10; c++) tick();
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_late_hi", HI, 32'h0);
    chk("abort_late_lo", LO, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide controller for the E stage of the 5-stage MIPS pipeline; owns the architectural HI/LO registers.
- Sequences multi-cycle mult/multu/div/divu with a busy counter and commits results to HI/LO at completion.
- Raises a stall request to the hazard unit when a D-stage HI/LO-using instruction would collide with an in-flight operation.
- HI/LO outputs feed the E/M pipeline register for mfhi/mflo write-back.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an HI/LO-writing op; qualifies md_op
md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
in_a  input  32  rs operand (forwarded value)
in_b  input  32  rt operand (forwarded value)
md_use_d  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
busy  output  1  operation in flight
stall_md  output  1  stall request to hazard unit (combinational)
HI  output  32  architectural HI
LO  output  32  architectural LO

Behaviour:
- Reset: at the first rising edge with rst=1, busy=0, counter=0, HI=0, LO=0, and pending results cleared; rst overrides all other inputs. Reset mid-operation aborts the operation; HI/LO are not updated by it.
- Idle accept condition: start=1, busy=0, md_op in 1..6. If start=1 while busy=1, the request is ignored entirely; the hazard unit must prevent this via stall_md.
- MULT/MULTU at accept edge:
  - compute the 64-bit product (signed or unsigned) of in_a and in_b; latch product[63:32] into pending_hi and product[31:0] into pending_lo;
  - load counter=MULT_CYCLES; set busy=1.
- DIV/DIVU at accept edge:
  - if in_b != 0: pending_lo = quotient, pending_hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign. 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - if in_b == 0: busy still runs DIV_CYCLES, and HI/LO are left unchanged at completion.
  - load counter=DIV_CYCLES; set busy=1.
- MTHI/MTLO: at the accept edge, HI (or LO) <= in_a. busy stays 0 and there is no latency.
- Busy phase, each edge with busy=1:
  - counter decrements.
  - When counter==1 at the edge: HI<=pending_hi and LO<=pending_lo (unless divide-by-zero); busy<=0; counter<=0.
  - Net timing: start in cycle 0, busy high in cycles 1..N, new HI/LO visible from cycle N+1.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. the same cycle in which the committed HI/LO first appear.
- Stall rule: stall_md = md_use_d & (busy | (start & md_op in 1..4)). It is purely combinational, with no registered delay.
- HI/LO change only on a completion edge, on an MTHI/MTLO accept, or on reset; they hold on all other cycles.
- md_op values NONE and 7 with start=1: no state change.

Test Plan:
- Reset with rst=1 for 2 cycles -> busy=0, HI=0, LO=0, stall_md=0.
- MULT in_a=0xFFFFFFFD (-3), in_b=5, start in cycle 0 -> busy=1 in cycles 1..5; in cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0. Same operands with MULTU -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV in_a=0xFFFFFFF9 (-7), in_b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- HI=0x11, LO=0x22 preloaded via MTHI/MTLO (visible the next cycle, busy stays 0); then DIV by in_b=0 -> busy for 10 cycles, HI=0x11 and LO=0x22 unchanged afterwards.
- MULT started; md_use_d=1 during cycles 0..5 -> stall_md=1 in cycles 0..5 and 0 in cycle 6. A start with md_op=MTHI issued in cycle 3 -> ignored, HI reflects only the product.
- DIVU started, rst asserted in cycle 4 -> next cycle busy=0, HI=0, LO=0; no late commit occurs in the following 10 cycles.
